// File: rtl/armleocpu_mem_responder.sv
// armleocpu_mem_responder
// Word-organised memory acting as the responder on the ArmleoCPU cache-to-memory
// transaction bus. Serves single and incrementing burst reads/writes with byte
// enables, one beat every two cycles, and reports misaligned, out-of-range and
// unsupported requests through transaction_response.
`timescale 1ns/1ps

module armleocpu_mem_responder #(
    parameter int          DEPTH_W   = 10,
    parameter logic [33:0] BASE_ADDR = 34'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        transaction,
    input  logic [2:0]  cmd,
    input  logic [33:0] address,
    input  logic [3:0]  burstcount,
    input  logic [31:0] wdata,
    input  logic [3:0]  wbyte_enable,
    output logic        transaction_done,
    output logic [2:0]  transaction_response,
    output logic [31:0] rdata
);

    localparam logic [2:0] CMD_NONE   = 3'd0;
    localparam logic [2:0] CMD_READ   = 3'd1;
    localparam logic [2:0] CMD_WRITE  = 3'd2;

    localparam logic [2:0] RESP_OKAY       = 3'd0;
    localparam logic [2:0] RESP_ADDR_ERROR = 3'd1;
    localparam logic [2:0] RESP_CMD_ERROR  = 3'd2;

    typedef enum logic [1:0] {
        IDLE,
        RESP,
        NEXT
    } state_t;

    // Storage is deliberately never reset; contents are unknown until written.
    logic [31:0] mem [0:(1 << DEPTH_W) - 1];

    state_t             state_q;
    logic [2:0]         cmd_q;
    logic [DEPTH_W:0]   idx_q;
    logic [3:0]         remaining_q;
    logic               done_q;
    logic [2:0]         resp_q;
    logic [31:0]        rdata_q;

    logic [31:0]        wordOffset;
    logic [DEPTH_W:0]   idleIdx;
    logic               idleGo;
    logic               cmdBad;
    logic               addrBad;
    logic               idleAccess;
    logic               nextAccess;
    logic [DEPTH_W-1:0] accessAddr;
    logic [2:0]         accessCmd;
    logic               memWrite;

    // Decode the first-beat request and select which word a beat touches this cycle.
    always_comb begin
        wordOffset = address[33:2] - BASE_ADDR[33:2];
        idleIdx    = wordOffset[DEPTH_W:0];
        idleGo     = (state_q == IDLE) && transaction && (cmd != CMD_NONE);
        cmdBad     = !((cmd == CMD_READ) || (cmd == CMD_WRITE)) || (burstcount == 4'd0);
        addrBad    = (address[1:0] != 2'b00) || (address < BASE_ADDR)
                     || ((wordOffset >> DEPTH_W) != 32'd0);
        idleAccess = idleGo && !cmdBad && !addrBad;
        nextAccess = (state_q == NEXT) && transaction && !idx_q[DEPTH_W];
        accessAddr = idleIdx[DEPTH_W-1:0];
        accessCmd  = cmd;
        if (state_q == NEXT) begin
            accessAddr = idx_q[DEPTH_W-1:0];
            accessCmd  = cmd_q;
        end
        memWrite = !rst && (idleAccess || nextAccess) && (accessCmd == CMD_WRITE);
    end

    // Commit the enabled byte lanes of an accepted write beat.
    always_ff @(posedge clk) begin
        if (memWrite) begin
            for (int b = 0; b < 4; b++) begin
                if (wbyte_enable[b]) begin
                    mem[accessAddr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // Transaction FSM: accept a beat, pulse done for one cycle, then advance or finish.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cmd_q       <= CMD_NONE;
            idx_q       <= '0;
            remaining_q <= 4'd0;
            done_q      <= 1'b0;
            resp_q      <= RESP_OKAY;
            rdata_q     <= 32'd0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (idleGo) begin
                        cmd_q       <= cmd;
                        idx_q       <= idleIdx;
                        remaining_q <= burstcount;
                        done_q      <= 1'b1;
                        state_q     <= RESP;
                        if (cmdBad) begin
                            resp_q  <= RESP_CMD_ERROR;
                            rdata_q <= 32'd0;
                        end else if (addrBad) begin
                            resp_q  <= RESP_ADDR_ERROR;
                            rdata_q <= 32'd0;
                        end else begin
                            resp_q <= RESP_OKAY;
                            if (cmd == CMD_READ) begin
                                rdata_q <= mem[accessAddr];
                            end
                        end
                    end
                end
                RESP: begin
                    if ((resp_q != RESP_OKAY) || (remaining_q <= 4'd1)) begin
                        state_q <= IDLE;
                    end else begin
                        state_q     <= NEXT;
                        idx_q       <= idx_q + 1'b1;
                        remaining_q <= remaining_q - 4'd1;
                    end
                end
                NEXT: begin
                    if (!transaction) begin
                        state_q <= IDLE;
                    end else if (idx_q[DEPTH_W]) begin
                        resp_q  <= RESP_ADDR_ERROR;
                        rdata_q <= 32'd0;
                        done_q  <= 1'b1;
                        state_q <= RESP;
                    end else begin
                        resp_q  <= RESP_OKAY;
                        done_q  <= 1'b1;
                        state_q <= RESP;
                        if (cmd_q == CMD_READ) begin
                            rdata_q <= mem[accessAddr];
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign transaction_done     = done_q;
    assign transaction_response = resp_q;
    assign rdata                = rdata_q;

endmodule

// File: tb/tb_armleocpu_mem_responder.sv
// Testbench for armleocpu_mem_responder: a bus master drives requests, expected
// beats are queued as each request is issued and popped as done pulses appear.
`timescale 1ns/1ps

module tb_armleocpu_mem_responder;

    localparam int          DEPTH_W = 4;
    localparam logic [33:0] BASE    = 34'h1000;

    logic        clk;
    logic        rst;
    logic        transaction;
    logic [2:0]  cmd;
    logic [33:0] address;
    logic [3:0]  burstcount;
    logic [31:0] wdata;
    logic [3:0]  wbyte_enable;
    logic        transaction_done;
    logic [2:0]  transaction_response;
    logic [31:0] rdata;

    typedef struct packed {
        logic [2:0]  resp;
        logic [31:0] data;
        logic        chk;
    } exp_t;

    exp_t        sbQ[$];
    logic [31:0] wData [16];
    logic [3:0]  wBe   [16];
    int          vectors;
    int          miscompares;
    logic        prevDone;

    armleocpu_mem_responder #(
        .DEPTH_W   (DEPTH_W),
        .BASE_ADDR (BASE)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .transaction          (transaction),
        .cmd                  (cmd),
        .address              (address),
        .burstcount           (burstcount),
        .wdata                (wdata),
        .wbyte_enable         (wbyte_enable),
        .transaction_done     (transaction_done),
        .transaction_response (transaction_response),
        .rdata                (rdata)
    );

    // Free-running clock, 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pushExpected(input logic [2:0] resp, input logic [31:0] data, input logic chk);
        exp_t e;
        e.resp = resp;
        e.data = data;
        e.chk  = chk;
        sbQ.push_back(e);
    endtask

    // Issue one request; waits for nDone done pulses, or drops transaction early after dropAfter.
    task automatic applyStimulus(input logic [2:0] c, input logic [33:0] a, input logic [3:0] bc,
                                 input int nDone, input int dropAfter);
        logic seen;
        transaction  = 1'b1;
        cmd          = c;
        address      = a;
        burstcount   = bc;
        wdata        = wData[0];
        wbyte_enable = wBe[0];
        for (int beat = 0; beat < nDone; beat++) begin
            seen = 1'b0;
            for (int w = 0; w < 8 && !seen; w++) begin
                @(negedge clk);
                if (transaction_done) seen = 1'b1;
            end
            checkOutput("doneSeen", 64'(seen), 64'd1);
            if (!seen) break;
            wdata        = wData[beat + 1];
            wbyte_enable = wBe[beat + 1];
            if (beat + 1 == dropAfter) break;
        end
        transaction = 1'b0;
        cmd         = 3'd0;
        repeat (4) @(negedge clk);
        checkOutput("queueDrained", 64'(sbQ.size()), 64'd0);
    endtask

    task automatic singleWrite(input logic [33:0] a, input logic [31:0] d, input logic [3:0] be);
        wData[0] = d;
        wBe[0]   = be;
        pushExpected(3'd0, 32'd0, 1'b0);
        applyStimulus(3'd2, a, 4'd1, 1, 0);
    endtask

    task automatic singleRead(input logic [33:0] a, input logic [31:0] d);
        pushExpected(3'd0, d, 1'b1);
        applyStimulus(3'd1, a, 4'd1, 1, 0);
    endtask

    task automatic errorReq(input logic [2:0] c, input logic [33:0] a, input logic [3:0] bc,
                            input logic [2:0] resp);
        wData[0] = 32'h0BAD_F00D;
        wBe[0]   = 4'hF;
        pushExpected(resp, 32'd0, 1'b1);
        applyStimulus(c, a, bc, 1, 0);
    endtask

    // Scoreboard monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && transaction_done) begin
            checkOutput("doneSpacing", 64'(prevDone), 64'd0);
            checkOutput("doneExpected", 64'(sbQ.size() > 0), 64'd1);
            if (sbQ.size() > 0) begin
                e = sbQ.pop_front();
                checkOutput("resp", 64'(transaction_response), 64'(e.resp));
                if (e.chk) checkOutput("rdata", 64'(rdata), 64'(e.data));
            end
        end
        prevDone = transaction_done;
    end

    // Global guard so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main test sequence.
    initial begin
        logic seen;
        vectors      = 0;
        miscompares  = 0;
        prevDone     = 1'b0;
        rst          = 1'b1;
        transaction  = 1'b0;
        cmd          = 3'd0;
        address      = 34'd0;
        burstcount   = 4'd0;
        wdata        = 32'd0;
        wbyte_enable = 4'd0;
        for (int i = 0; i < 16; i++) begin
            wData[i] = 32'd0;
            wBe[i]   = 4'hF;
        end

        repeat (3) @(negedge clk);
        checkOutput("rstDone", 64'(transaction_done), 64'd0);
        checkOutput("rstResp", 64'(transaction_response), 64'd0);
        checkOutput("rstRdata", 64'(rdata), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] single write/read");
        singleWrite(BASE + 34'h10, 32'hDEAD_BEEF, 4'hF);
        singleRead(BASE + 34'h10, 32'hDEAD_BEEF);

        $display("[TB] byte enables");
        singleWrite(BASE + 34'h30, 32'hFFFF_FFFF, 4'hF);
        singleWrite(BASE + 34'h30, 32'h1122_3344, 4'b0101);
        singleRead(BASE + 34'h30, 32'hFF22_FF44);

        $display("[TB] bursts");
        for (int i = 0; i < 4; i++) begin
            wData[i] = 32'(i + 1);
            wBe[i]   = 4'hF;
            pushExpected(3'd0, 32'd0, 1'b0);
        end
        applyStimulus(3'd2, BASE + 34'h20, 4'd4, 4, 0);
        for (int i = 0; i < 4; i++) pushExpected(3'd0, 32'(i + 1), 1'b1);
        applyStimulus(3'd1, BASE + 34'h20, 4'd4, 4, 0);

        $display("[TB] error responses");
        errorReq(3'd2, BASE + 34'h12, 4'd4, 3'd1);
        errorReq(3'd3, BASE + 34'h10, 4'd1, 3'd2);
        errorReq(3'd2, BASE + 34'h10, 4'd0, 3'd2);
        errorReq(3'd3, BASE + 34'h12, 4'd1, 3'd2);
        errorReq(3'd2, BASE + 34'h40, 4'd1, 3'd1);
        errorReq(3'd2, BASE - 34'h4,  4'd1, 3'd1);
        singleRead(BASE + 34'h10, 32'hDEAD_BEEF);

        $display("[TB] wrap past top");
        singleWrite(BASE + 34'h3C, 32'hCAFE_F00D, 4'hF);
        pushExpected(3'd0, 32'hCAFE_F00D, 1'b1);
        pushExpected(3'd1, 32'd0, 1'b1);
        applyStimulus(3'd1, BASE + 34'h3C, 4'd3, 2, 0);

        $display("[TB] master abort");
        pushExpected(3'd0, 32'd1, 1'b1);
        applyStimulus(3'd1, BASE + 34'h20, 4'd4, 4, 1);
        singleRead(BASE + 34'h24, 32'd2);

        $display("[TB] reset mid-burst");
        for (int i = 0; i < 4; i++) pushExpected(3'd0, 32'(i + 1), 1'b1);
        transaction = 1'b1;
        cmd         = 3'd1;
        address     = BASE + 34'h20;
        burstcount  = 4'd4;
        seen        = 1'b0;
        for (int w = 0; w < 8 && !seen; w++) begin
            @(negedge clk);
            if (transaction_done) seen = 1'b1;
        end
        checkOutput("rstBurstDone", 64'(seen), 64'd1);
        #1 rst = 1'b1;
        #1;
        checkOutput("asyncRstDone", 64'(transaction_done), 64'd0);
        checkOutput("asyncRstResp", 64'(transaction_response), 64'd0);
        checkOutput("asyncRstRdata", 64'(rdata), 64'd0);
        sbQ.delete();
        transaction = 1'b0;
        cmd         = 3'd0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        singleRead(BASE + 34'h28, 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/armleocpu_mem_responder.md
# armleocpu_mem_responder

Single-port word memory that acts as the responder end of the ArmleoCPU cache-to-memory transaction bus (`transaction`/`cmd`/`transaction_done`/`transaction_response`). One instance attaches to either the data-cache port or the instruction-cache port of the core. It serves single and incrementing burst reads and writes, applies byte enables, and returns error responses for misaligned, out-of-range or unsupported requests. It is the simulation and boot-RAM counterpart of the cache master and contains no cache logic.

## Interface
Parameters:
- `DEPTH_W`, 10: log2 of memory size in 32-bit words.
- `BASE_ADDR`, 34'h0: byte address of word 0; must be word-aligned.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `transaction`  in  1  master request valid; held high for the whole burst.
- `cmd`  in  3  request command: 0 NONE, 1 READ, 2 WRITE; 3–7 unsupported.
- `address`  in  34  byte address of the first beat; sampled only on the first beat.
- `burstcount`  in  4  number of beats, 1–15; sampled only on the first beat.
- `wdata`  in  32  write data for the current beat.
- `wbyte_enable`  in  4  byte lanes written for the current beat.
- `transaction_done`  out  1  one-cycle pulse per completed beat.
- `transaction_response`  out  3  valid while `transaction_done`=1: 0 OKAY, 1 ADDR_ERROR, 2 CMD_ERROR.
- `rdata`  out  32  read data, valid while `transaction_done`=1 and the response is OKAY.

## Operation
- Storage is `2**DEPTH_W` × 32-bit words. It is not reset and its contents are unknown until written.
- Registered state:
  - FSM: IDLE, RESP, NEXT.
  - latched command.
  - word index counter, `DEPTH_W`+1 bits, so overflow past the top is detectable.
  - beats-remaining counter, 4 bits.
- Beat execution is called "accept" below.
  - Reads: latch `mem[idx]` into `rdata`.
  - Writes: update the byte lanes selected by `wbyte_enable` with `wdata`. Lanes with a 0 enable keep their contents.
- IDLE:
  - With `transaction`=0, or `cmd`=NONE: stay in IDLE.
  - Otherwise latch `cmd`, compute `idx = (address − BASE_ADDR) >> 2`, load remaining = `burstcount`.
  - Checks, in priority order:
    1. `cmd` not READ/WRITE, or `burstcount`=0 → CMD_ERROR.
    2. `address[1:0]`≠0, `address` < `BASE_ADDR`, or `idx` ≥ `2**DEPTH_W` → ADDR_ERROR.
    3. Otherwise accept beat 0 → OKAY.
  - Next state is RESP in all three cases.
- RESP:
  - `transaction_done`=1 for exactly this cycle.
  - Then: if the response was an error or remaining becomes 0 → IDLE.
  - Otherwise → NEXT; increment `idx`, decrement remaining.
- NEXT:
  - `transaction`=1 and `idx` < `2**DEPTH_W` → accept beat with current `wdata`/`wbyte_enable` → RESP (OKAY).
  - `idx` has run past the top of memory → no access → RESP (ADDR_ERROR). The burst terminates and the remaining beats are dropped.
  - `transaction`=0 → master abort; → IDLE with no done and no memory access.
- `cmd`, `address` and `burstcount` changes during a burst are ignored.
- Error beats never write memory and drive `rdata`=0.

## Timing
- Reset values: state IDLE, `transaction_done`=0, `transaction_response`=0, `rdata`=0, counters 0. Reset is asynchronous and takes effect mid-burst. No done is issued for an interrupted beat, and a write beat already committed stays in memory.
- Latency: a beat accepted at edge N shows `transaction_done` during cycle N+1.
- Throughput: one beat per 2 cycles. A 4-beat burst first sampled at edge 0 produces done pulses after edges 0, 2, 4 and 6, and the FSM is IDLE after edge 7.
- Back-to-back: a master may raise `transaction` for a new request in the cycle after the final done. It is sampled in IDLE at the next edge.
- `transaction_done` is never high on two consecutive cycles.
- `transaction_response` and `rdata` are registered and hold their values until the next done pulse.
- `wdata`/`wbyte_enable` are sampled at the accept edge. The master advances them after seeing done.

## Test plan
- Single write then read: WRITE `address`=BASE+0x10, `wdata`=0xDEADBEEF, be=4'hF, burst 1. Then READ of the same address → done one cycle after each accept, response 0, `rdata`=0xDEADBEEF.
- Byte enable: write 0x11223344 with be=4'b0101 over 0xFFFFFFFF, then read → `rdata`=0xFF22FF44.
- Burst: 4-beat WRITE at BASE+0x20 with data 1, 2, 3, 4, then 4-beat READ → four OKAY dones spaced 2 cycles apart, `rdata` = 1, 2, 3, 4.
- Errors:
  - `address`=BASE+0x2 → one done with response 1.
  - `cmd`=3 → one done with response 2.
  - `burstcount`=0 → response 2.
  - None of these modify memory.
- Wrap-past-top: 3-beat READ at the last word (`DEPTH_W`=4, BASE+0x3C) → beat 0 OKAY, beat 1 ADDR_ERROR with `rdata`=0, then IDLE with no third done.
- Abort and reset:
  - Drop `transaction` during NEXT → no further done, FSM IDLE, next request served normally.
  - Assert `rst` mid-burst → outputs 0 immediately, without waiting for a clock edge.
